// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StLuStall = 1'b1
  } state_e;

  // Largest supported load latency; the longest stall is LoadLatMax + 1 cycles.
  localparam int unsigned LoadLatMax = 7;
  localparam int unsigned CntW       = 3;

  // cnt_t holds the remaining stall count; len_t holds a full stall length (up to 8).
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [CntW:0]   len_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one destination register against both ID source registers.
module hazard_match #(
  parameter int unsigned RegAddrW = 5
) (
  input  logic                en_i,
  input  logic [RegAddrW-1:0] rd_i,
  input  logic [RegAddrW-1:0] rs_i,
  input  logic [RegAddrW-1:0] rt_i,
  output logic                match_o
);

  logic rd_nonzero;
  logic hit_rs;
  logic hit_rt;

  // Register 0 is hardwired, so a write to it can never create a dependency.
  assign rd_nonzero = |rd_i;
  assign hit_rs     = (rd_i == rs_i);
  assign hit_rt     = (rd_i == rt_i);
  assign match_o    = en_i & rd_nonzero & (hit_rs | hit_rt);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, dmem freeze,
// taken-branch flush and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned LOAD_LAT     = 1,
  parameter bit          BRANCH_IN_ID = 1'b1,
  parameter int unsigned PERF_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] if_id_rs_i,
  input  logic [REG_ADDR_W-1:0] if_id_rt_i,
  input  logic                  branch_i,
  input  logic                  branch_taken_i,
  input  logic                  id_ex_mem_read_i,
  input  logic                  id_ex_reg_write_i,
  input  logic [REG_ADDR_W-1:0] id_ex_rd_i,
  input  logic                  ex_mem_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd_i,
  input  logic                  dmem_stall_i,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  id_ex_bubble_o,
  output logic                  freeze_o,
  output logic                  if_id_flush_o,
  output logic [PERF_W-1:0]     stall_cnt_o
);

  localparam int unsigned LoadLatClamped =
      (LOAD_LAT > LoadLatMax) ? LoadLatMax : ((LOAD_LAT < 1) ? 1 : LOAD_LAT);
  localparam len_t LoadLatLen = len_t'(LoadLatClamped);

  state_e            state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic ld_ex_hit;
  logic alu_ex_hit;
  logic ld_mem_hit;
  logic br_chk;
  logic br_hit;
  len_t stall_len;
  cnt_t stall_rem;

  hazard_match #(
    .RegAddrW (REG_ADDR_W)
  ) u_match_ld_ex (
    .en_i    (id_ex_mem_read_i),
    .rd_i    (id_ex_rd_i),
    .rs_i    (if_id_rs_i),
    .rt_i    (if_id_rt_i),
    .match_o (ld_ex_hit)
  );

  hazard_match #(
    .RegAddrW (REG_ADDR_W)
  ) u_match_alu_ex (
    .en_i    (id_ex_reg_write_i & ~id_ex_mem_read_i),
    .rd_i    (id_ex_rd_i),
    .rs_i    (if_id_rs_i),
    .rt_i    (if_id_rt_i),
    .match_o (alu_ex_hit)
  );

  hazard_match #(
    .RegAddrW (REG_ADDR_W)
  ) u_match_ld_mem (
    .en_i    (ex_mem_mem_read_i),
    .rd_i    (ex_mem_rd_i),
    .rs_i    (if_id_rs_i),
    .rt_i    (if_id_rt_i),
    .match_o (ld_mem_hit)
  );

  assign br_chk = BRANCH_IN_ID & branch_i;
  assign br_hit = br_chk & (alu_ex_hit | ld_mem_hit);

  // A branch consuming a load needs one extra cycle beyond the plain load-use gap.
  assign stall_len = ld_ex_hit ? (LoadLatLen + len_t'(br_chk)) : len_t'(1);
  assign stall_rem = cnt_t'(stall_len - len_t'(1));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_bubble_o = 1'b0;
    freeze_o       = 1'b0;
    if_id_flush_o  = 1'b0;

    if (rst_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
      state_d        = StRun;
      cnt_d          = '0;
    end else if (dmem_stall_i) begin
      // Everything holds; hazards are re-evaluated once memory is ready.
      freeze_o      = 1'b1;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ld_ex_hit || br_hit) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
            if (stall_len > len_t'(1)) begin
              state_d = StLuStall;
              cnt_d   = stall_rem;
            end
          end else begin
            if_id_flush_o = branch_taken_i;
          end
        end
        StLuStall: begin
          pc_write_o     = 1'b0;
          if_id_write_o  = 1'b0;
          id_ex_bubble_o = 1'b1;
          if (cnt_q <= cnt_t'(1)) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    perf_d = perf_q;
    if (!pc_write_o && !(&perf_q)) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  assign stall_cnt_o = perf_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameterisations share one stimulus stream.
module tb_hazard_ctrl;

  // Expected control word: {pc_write, if_id_write, bubble, freeze, flush}.
  localparam logic [4:0] IDLE  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00100;
  localparam logic [4:0] FRZ   = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11001;
  localparam logic [4:0] RST   = 5'b00100;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] fl;  // {branch, taken, ld_ex, wr_ex, ld_mem, dmem_stall}
    logic [4:0] rdx;
    logic [4:0] rdm;
    logic [4:0] e0;
    logic [4:0] e1;
    logic [4:0] e3;
  } cyc_t;

  typedef struct {
    int         inst;
    logic [4:0] want;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt, rdx, rdm;
  logic       br, tk, ldx, wrx, ldm, ds;

  logic        pc0, ifw0, bub0, frz0, fl0;
  logic        pc1, ifw1, bub1, frz1, fl1;
  logic        pc3, ifw3, bub3, frz3, fl3;
  logic [31:0] cnt0, cnt1;
  logic [3:0]  cnt3;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(2), .BRANCH_IN_ID(1'b0), .PERF_W(32)) u_dut0 (
    .clk_i (clk), .rst_i (rst), .if_id_rs_i (rs), .if_id_rt_i (rt), .branch_i (br),
    .branch_taken_i (tk), .id_ex_mem_read_i (ldx), .id_ex_reg_write_i (wrx),
    .id_ex_rd_i (rdx), .ex_mem_mem_read_i (ldm), .ex_mem_rd_i (rdm), .dmem_stall_i (ds),
    .pc_write_o (pc0), .if_id_write_o (ifw0), .id_ex_bubble_o (bub0), .freeze_o (frz0),
    .if_id_flush_o (fl0), .stall_cnt_o (cnt0)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .BRANCH_IN_ID(1'b1), .PERF_W(32)) u_dut1 (
    .clk_i (clk), .rst_i (rst), .if_id_rs_i (rs), .if_id_rt_i (rt), .branch_i (br),
    .branch_taken_i (tk), .id_ex_mem_read_i (ldx), .id_ex_reg_write_i (wrx),
    .id_ex_rd_i (rdx), .ex_mem_mem_read_i (ldm), .ex_mem_rd_i (rdm), .dmem_stall_i (ds),
    .pc_write_o (pc1), .if_id_write_o (ifw1), .id_ex_bubble_o (bub1), .freeze_o (frz1),
    .if_id_flush_o (fl1), .stall_cnt_o (cnt1)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .BRANCH_IN_ID(1'b1), .PERF_W(4)) u_dut3 (
    .clk_i (clk), .rst_i (rst), .if_id_rs_i (rs), .if_id_rt_i (rt), .branch_i (br),
    .branch_taken_i (tk), .id_ex_mem_read_i (ldx), .id_ex_reg_write_i (wrx),
    .id_ex_rd_i (rdx), .ex_mem_mem_read_i (ldm), .ex_mem_rd_i (rdm), .dmem_stall_i (ds),
    .pc_write_o (pc3), .if_id_write_o (ifw3), .id_ex_bubble_o (bub3), .freeze_o (frz3),
    .if_id_flush_o (fl3), .stall_cnt_o (cnt3)
  );

  function automatic logic [4:0] ctrl_of(input int inst);
    case (inst)
      0:       return {pc0, ifw0, bub0, frz0, fl0};
      1:       return {pc1, ifw1, bub1, frz1, fl1};
      default: return {pc3, ifw3, bub3, frz3, fl3};
    endcase
  endfunction

  function automatic cyc_t mk(input logic r, input logic [4:0] a_rs, a_rt,
                              input logic [5:0] f, input logic [4:0] a_rdx, a_rdm,
                              input logic [4:0] x0, x1, x3);
    cyc_t c;
    c.rst = r;   c.rs = a_rs; c.rt = a_rt; c.fl = f;
    c.rdx = a_rdx; c.rdm = a_rdm;
    c.e0 = x0;   c.e1 = x1;   c.e3 = x3;
    return c;
  endfunction

  // Drive one cycle of stimulus and queue the outputs it must produce.
  task automatic apply(input cyc_t c);
    rst = c.rst; rs = c.rs; rt = c.rt; rdx = c.rdx; rdm = c.rdm;
    {br, tk, ldx, wrx, ldm, ds} = c.fl;
    sb.push_back('{inst: 0, want: c.e0});
    sb.push_back('{inst: 1, want: c.e1});
    sb.push_back('{inst: 3, want: c.e3});
  endtask

  task automatic do_reset();
    apply(mk(1'b1, 5'd0, 5'd0, 6'b000000, 5'd0, 5'd0, RST, RST, RST));
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc_t tbl[$];
    exp_t e;
    tbl.push_back(mk(1'b1, 5'd5, 5'd5, 6'b001100, 5'd5, 5'd0, RST, RST, RST));
    tbl.push_back(mk(1'b0, 5'd0, 5'd0, 6'b000000, 5'd0, 5'd0, IDLE, IDLE, IDLE));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (ctrl_of(e.inst) !== e.want) begin
          bad++;
          $display("FAIL reset[%0d] dut%0d ctrl got=%b want=%b", i, e.inst, ctrl_of(e.inst),
                   e.want);
        end
      end
      if (i == 1) begin
        total++;
        if (cnt0 !== 32'd0 || cnt1 !== 32'd0 || cnt3 !== 4'd0) begin
          bad++;
          $display("FAIL reset cnt got=%0d/%0d/%0d want=0/0/0", cnt0, cnt1, cnt3);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    cyc_t tbl[$];
    exp_t e;
    do_reset();
    tbl.push_back(mk(1'b0, 5'd0, 5'd5, 6'b001100, 5'd5, 5'd0, STALL, STALL, STALL));
    tbl.push_back(mk(1'b0, 5'd0, 5'd5, 6'b000010, 5'd0, 5'd5, STALL, IDLE, STALL));
    tbl.push_back(mk(1'b0, 5'd0, 5'd0, 6'b000000, 5'd0, 5'd0, IDLE, IDLE, STALL));
    // Load/branch on r0 never stalls.
    tbl.push_back(mk(1'b0, 5'd0, 5'd0, 6'b101110, 5'd0, 5'd0, IDLE, IDLE, IDLE));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (ctrl_of(e.inst) !== e.want) begin
          bad++;
          $display("FAIL load_use[%0d] dut%0d ctrl got=%b want=%b", i, e.inst,
                   ctrl_of(e.inst), e.want);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (cnt0 !== 32'd2 || cnt1 !== 32'd1 || cnt3 !== 4'd3) begin
      bad++;
      $display("FAIL load_use cnt got=%0d/%0d/%0d want=2/1/3", cnt0, cnt1, cnt3);
    end
  endtask

  task automatic test_branch_load();
    cyc_t tbl[$];
    exp_t e;
    do_reset();
    tbl.push_back(mk(1'b0, 5'd8, 5'd0, 6'b101100, 5'd8, 5'd0, STALL, STALL, STALL));
    tbl.push_back(mk(1'b0, 5'd8, 5'd0, 6'b100010, 5'd0, 5'd8, STALL, STALL, STALL));
    tbl.push_back(mk(1'b0, 5'd8, 5'd0, 6'b100000, 5'd0, 5'd0, IDLE, IDLE, STALL));
    tbl.push_back(mk(1'b0, 5'd8, 5'd0, 6'b100000, 5'd0, 5'd0, IDLE, IDLE, STALL));
    tbl.push_back(mk(1'b0, 5'd8, 5'd0, 6'b100000, 5'd0, 5'd0, IDLE, IDLE, IDLE));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (ctrl_of(e.inst) !== e.want) begin
          bad++;
          $display("FAIL branch_load[%0d] dut%0d ctrl got=%b want=%b", i, e.inst,
                   ctrl_of(e.inst), e.want);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (cnt0 !== 32'd2 || cnt1 !== 32'd2 || cnt3 !== 4'd4) begin
      bad++;
      $display("FAIL branch_load cnt got=%0d/%0d/%0d want=2/2/4", cnt0, cnt1, cnt3);
    end
  endtask

  task automatic test_branch_alu_flush();
    cyc_t tbl[$];
    exp_t e;
    do_reset();
    // Taken flush is suppressed while stalling and reappears once the branch re-resolves.
    tbl.push_back(mk(1'b0, 5'd0, 5'd3, 6'b110100, 5'd3, 5'd0, FLUSH, STALL, STALL));
    tbl.push_back(mk(1'b0, 5'd0, 5'd3, 6'b110000, 5'd0, 5'd3, FLUSH, FLUSH, FLUSH));
    tbl.push_back(mk(1'b0, 5'd9, 5'd0, 6'b100010, 5'd0, 5'd9, IDLE, STALL, STALL));
    tbl.push_back(mk(1'b0, 5'd4, 5'd0, 6'b000100, 5'd4, 5'd0, IDLE, IDLE, IDLE));
    tbl.push_back(mk(1'b0, 5'd0, 5'd0, 6'b100100, 5'd0, 5'd0, IDLE, IDLE, IDLE));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (ctrl_of(e.inst) !== e.want) begin
          bad++;
          $display("FAIL branch_alu[%0d] dut%0d ctrl got=%b want=%b", i, e.inst,
                   ctrl_of(e.inst), e.want);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (cnt0 !== 32'd0 || cnt1 !== 32'd2 || cnt3 !== 4'd2) begin
      bad++;
      $display("FAIL branch_alu cnt got=%0d/%0d/%0d want=0/2/2", cnt0, cnt1, cnt3);
    end
  endtask

  task automatic test_freeze();
    cyc_t tbl[$];
    exp_t e;
    do_reset();
    tbl.push_back(mk(1'b0, 5'd0, 5'd8, 6'b001100, 5'd8, 5'd0, STALL, STALL, STALL));
    tbl.push_back(mk(1'b0, 5'd0, 5'd8, 6'b000011, 5'd0, 5'd8, FRZ, FRZ, FRZ));
    tbl.push_back(mk(1'b0, 5'd0, 5'd8, 6'b000011, 5'd0, 5'd8, FRZ, FRZ, FRZ));
    tbl.push_back(mk(1'b0, 5'd0, 5'd8, 6'b000010, 5'd0, 5'd8, STALL, IDLE, STALL));
    tbl.push_back(mk(1'b0, 5'd0, 5'd0, 6'b000000, 5'd0, 5'd0, IDLE, IDLE, STALL));
    // Freeze and hazard together: freeze first, hazard once memory is ready.
    tbl.push_back(mk(1'b0, 5'd0, 5'd5, 6'b001101, 5'd5, 5'd0, FRZ, FRZ, FRZ));
    tbl.push_back(mk(1'b0, 5'd0, 5'd5, 6'b001100, 5'd5, 5'd0, STALL, STALL, STALL));
    tbl.push_back(mk(1'b0, 5'd0, 5'd0, 6'b000000, 5'd0, 5'd0, STALL, IDLE, STALL));
    tbl.push_back(mk(1'b0, 5'd0, 5'd0, 6'b000000, 5'd0, 5'd0, IDLE, IDLE, STALL));
    tbl.push_back(mk(1'b0, 5'd0, 5'd0, 6'b000000, 5'd0, 5'd0, IDLE, IDLE, IDLE));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (ctrl_of(e.inst) !== e.want) begin
          bad++;
          $display("FAIL freeze[%0d] dut%0d ctrl got=%b want=%b", i, e.inst, ctrl_of(e.inst),
                   e.want);
        end
      end
      if (i == 5) begin
        total++;
        if (cnt3 !== 4'd5) begin
          bad++;
          $display("FAIL freeze window cnt got=%0d want=5", cnt3);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (cnt0 !== 32'd7 || cnt1 !== 32'd5 || cnt3 !== 4'd9) begin
      bad++;
      $display("FAIL freeze cnt got=%0d/%0d/%0d want=7/5/9", cnt0, cnt1, cnt3);
    end
  endtask

  task automatic test_reset_mid_stall();
    cyc_t tbl[$];
    exp_t e;
    do_reset();
    tbl.push_back(mk(1'b0, 5'd0, 5'd8, 6'b001100, 5'd8, 5'd0, STALL, STALL, STALL));
    tbl.push_back(mk(1'b1, 5'd0, 5'd0, 6'b000001, 5'd0, 5'd0, RST, RST, RST));
    tbl.push_back(mk(1'b0, 5'd0, 5'd0, 6'b000000, 5'd0, 5'd0, IDLE, IDLE, IDLE));
    tbl.push_back(mk(1'b0, 5'd0, 5'd0, 6'b000000, 5'd0, 5'd0, IDLE, IDLE, IDLE));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (ctrl_of(e.inst) !== e.want) begin
          bad++;
          $display("FAIL mid_reset[%0d] dut%0d ctrl got=%b want=%b", i, e.inst,
                   ctrl_of(e.inst), e.want);
        end
      end
      if (i == 2) begin
        total++;
        if (cnt0 !== 32'd0 || cnt1 !== 32'd0 || cnt3 !== 4'd0) begin
          bad++;
          $display("FAIL mid_reset cnt got=%0d/%0d/%0d want=0/0/0", cnt0, cnt1, cnt3);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    cyc_t tbl[$];
    exp_t e;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      tbl.push_back(mk(1'b0, 5'd0, 5'd0, 6'b000001, 5'd0, 5'd0, FRZ, FRZ, FRZ));
    end
    tbl.push_back(mk(1'b0, 5'd0, 5'd0, 6'b000000, 5'd0, 5'd0, IDLE, IDLE, IDLE));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (ctrl_of(e.inst) !== e.want) begin
          bad++;
          $display("FAIL saturate[%0d] dut%0d ctrl got=%b want=%b", i, e.inst,
                   ctrl_of(e.inst), e.want);
        end
      end
      if (i == 15) begin
        total++;
        if (cnt3 !== 4'd15) begin
          bad++;
          $display("FAIL saturate reach got=%0d want=15", cnt3);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (cnt3 !== 4'd15 || cnt1 !== 32'd20 || cnt0 !== 32'd20) begin
      bad++;
      $display("FAIL saturate hold got=%0d/%0d/%0d want=20/20/15", cnt0, cnt1, cnt3);
    end
  endtask

  initial begin
    rst = 1'b1;
    rs = '0; rt = '0; rdx = '0; rdm = '0;
    br = 1'b0; tk = 1'b0; ldx = 1'b0; wrx = 1'b0; ldm = 1'b0; ds = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu_flush();
    test_freeze();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage CPU, replacing the single-cycle load-use detector. It sits beside the IF/ID and ID/EX pipeline registers and drives the PC, IF/ID, ID/EX and later-stage write enables. Beyond load-use it handles:
- multi-cycle load latency
- branch-in-ID operand dependencies
- data-memory wait freezes
- taken-branch IF/ID flush
- a saturating stall-cycle counter for performance reporting

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width
- LOAD_LAT, 1, stall cycles required between a load in EX and a dependent instruction in ID (1..7)
- BRANCH_IN_ID, 1, 1 = branches resolve in ID and need operand hazard checks; 0 = branch checks disabled
- PERF_W, 32, width of stall counter

Ports:
- clk_i  in  1  clock; single clock domain, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- if_id_rs_i, if_id_rt_i  in  REG_ADDR_W  source registers of instruction in ID
- branch_i  in  1  ID instruction is a branch
- branch_taken_i  in  1  ID branch resolved taken this cycle
- id_ex_mem_read_i, id_ex_reg_write_i  in  1  EX-stage instruction is a load / writes a register
- id_ex_rd_i  in  REG_ADDR_W  EX-stage destination register
- ex_mem_mem_read_i  in  1  MEM-stage instruction is a load
- ex_mem_rd_i  in  REG_ADDR_W  MEM-stage destination register
- dmem_stall_i  in  1  data memory not ready
- pc_write_o  out  1  1 = PC may update
- if_id_write_o  out  1  1 = IF/ID may update
- id_ex_bubble_o  out  1  1 = load NOP into ID/EX
- freeze_o  out  1  1 = hold ID/EX, EX/MEM, MEM/WB
- if_id_flush_o  out  1  1 = clear IF/ID
- stall_cnt_o  out  PERF_W  total stall cycles since reset

## Operation
- Match rule: a register match requires equal addresses and a nonzero address. Register 0 never causes a hazard.
- States: RUN and LU_STALL. A separate freeze overlays both states.
- Priority: reset > freeze > data stall > flush.
- Freeze:
  - Condition: dmem_stall_i=1.
  - Outputs: freeze_o=1, pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=0, if_id_flush_o=0.
  - State and down-counter hold their values.
  - Other hazards are not evaluated.
- Load-use detect (RUN only): id_ex_mem_read_i and id_ex_rd_i matches if_id_rs_i or if_id_rt_i.
  - Stall length N = LOAD_LAT, or LOAD_LAT+1 when branch_i=1 and BRANCH_IN_ID=1.
- Branch detect (RUN only, BRANCH_IN_ID=1, branch_i=1). Either condition gives N=1:
  - id_ex_reg_write_i and !id_ex_mem_read_i and id_ex_rd_i matches rs/rt;
  - ex_mem_mem_read_i and ex_mem_rd_i matches rs/rt.
- Stall cycle outputs: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, if_id_flush_o=0.
- Stall sequencing:
  - The first stall cycle is the detection cycle itself (combinational).
  - If N>1: go to LU_STALL with remaining count N-1.
  - LU_STALL stalls unconditionally and decrements each non-frozen cycle.
  - Return to RUN after the cycle in which the count reaches 1. No new detection is evaluated in LU_STALL.
- Flush: if_id_flush_o = branch_taken_i, only in RUN with no stall and no freeze. A suppressed flush is not remembered; the branch re-resolves after the stall.
- Idle (RUN, no hazard): pc_write_o=1, if_id_write_o=1, all other control outputs 0.
- stall_cnt_o:
  - Increments on every cycle with pc_write_o=0, freeze cycles included.
  - Saturates at all-ones.

## Timing
- Reset, while rst_i=1: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, freeze_o=0, if_id_flush_o=0.
- Reset, first edge: state := RUN, count := 0, stall_cnt_o := 0.
- Reset mid-stall abandons the stall immediately.
- Latency: hazard outputs are combinational from inputs and state, valid in the detection cycle. stall_cnt_o updates one edge later.
- A load-use hazard stalls exactly N consecutive non-frozen cycles. Freeze cycles inside the window extend it without consuming count.
- dmem_stall_i and a hazard in the same cycle: freeze wins. The hazard is re-evaluated when the freeze ends, because inputs are held.
- LOAD_LAT=1 with no branch never enters LU_STALL, matching the legacy single-bubble behaviour.

## Structure
- hazard_pkg holds:
  - the state enum (RUN, LU_STALL);
  - the LOAD_LAT bound constant (7);
  - the down-counter width, 3 bits, sized for LOAD_LAT+1 ≤ 8.
- Sub-module hazard_match compares one destination against rs and rt with zero-register exclusion. It is instantiated three times: ID/EX load, ID/EX ALU, EX/MEM load.

## Test plan
- LOAD_LAT=1, load writes r5 in EX, ID uses rt=r5 -> exactly 1 cycle with pc_write_o=0 and id_ex_bubble_o=1; stall_cnt_o=1.
- LOAD_LAT=3, load r8 in EX, ID branch on rs=r8 -> 4 stall cycles, then pc_write_o=1. Same with dest r0 -> no stall.
- BRANCH_IN_ID=1, ALU writes r3 in EX, ID branch reads r3 -> 1 stall. Next cycle, branch_taken_i=1 -> if_id_flush_o=1.
- LOAD_LAT=3 stall, dmem_stall_i high for 2 cycles in the 2nd stall cycle -> freeze_o=1 for 2 cycles; total pc_write_o=0 run is 5 cycles; stall_cnt_o=5.
- rst_i asserted in a LU_STALL cycle -> next cycle in RUN with stall_cnt_o=0; no residual stall after rst_i falls.
- Force stall_cnt_o to saturation with PERF_W=4 -> holds 15.
